// File: rtl/square_seq_pkg.sv
// Shared helpers for the sequential arithmetic blocks: width math used to size
// iteration counters.
package square_seq_pkg;

  // Ceiling log2 with a floor of 1 so a counter always has at least one bit.
  function automatic int clog2_min1(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/square_seq_if.sv
// Start/ready handshake bundle for the sequential squarer: the controller drives
// start with A, and the squarer returns O, ready and busy.
interface square_seq_if #(
  parameter int N = 4
);
  // start is a request sampled only while the block is idle; A is captured on
  // that same edge. ready is a level that stays high until the next accepted start.
  logic             start;
  logic [N-1:0]     A;
  logic [2*N-1:0]   O;
  logic             ready;
  logic             busy;

  modport master (output start, output A, input O, input ready, input busy);
  modport slave  (input start, input A, output O, output ready, output busy);
endinterface

// File: rtl/square_seq_step.sv
// One shift-and-add step of the squarer: adds x shifted by cnt into acc when
// bit cnt of x is set.
module square_seq_step #(
  parameter int N = 4,
  parameter int L = 2
) (
  input  logic [N-1:0]   x,
  input  logic [2*N-1:0] acc,
  input  logic [L-1:0]   cnt,
  output logic [2*N-1:0] acc_next
);

  logic [2*N-1:0] x_wide;
  logic [2*N-1:0] addend;

  assign x_wide   = {{N{1'b0}}, x};
  assign addend   = x[cnt] ? (x_wide << cnt) : '0;
  // Cannot overflow: the largest square (2^N-1)^2 fits in 2N bits.
  assign acc_next = acc + addend;

endmodule

// File: rtl/square_seq.sv
// Sequential squarer O = A*A: one partial product per cycle over N cycles, then
// a DONE cycle that publishes the result and raises ready.
module square_seq
  import square_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  square_seq_if.slave  bus,
  output logic [1:0]   state_dbg
);

  localparam int L = clog2_min1(N);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  state_t          state, state_next;
  logic [N-1:0]    x, x_next;
  logic [2*N-1:0]  acc, acc_next;
  logic [2*N-1:0]  step_acc;
  logic [L-1:0]    cnt, cnt_next;
  logic [2*N-1:0]  o_reg, o_next;
  logic            ready_reg, ready_next;

  square_seq_step #(.N(N), .L(L)) u_step (
    .x        (x),
    .acc      (acc),
    .cnt      (cnt),
    .acc_next (step_acc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      x         <= '0;
      acc       <= '0;
      cnt       <= '0;
      o_reg     <= '0;
      ready_reg <= 1'b0;
    end else begin
      state     <= state_next;
      x         <= x_next;
      acc       <= acc_next;
      cnt       <= cnt_next;
      o_reg     <= o_next;
      ready_reg <= ready_next;
    end
  end

  always_comb begin
    state_next = state;
    x_next     = x;
    acc_next   = acc;
    cnt_next   = cnt;
    o_next     = o_reg;
    ready_next = ready_reg;
    case (state)
      IDLE: begin
        if (bus.start) begin
          x_next     = bus.A;
          acc_next   = '0;
          cnt_next   = '0;
          ready_next = 1'b0;
          state_next = RUN;
        end
      end
      RUN: begin
        acc_next = step_acc;
        cnt_next = cnt + L'(1);
        if (cnt == L'(N - 1)) state_next = DONE;
      end
      DONE: begin
        o_next     = acc;
        ready_next = 1'b1;
        state_next = IDLE;
      end
      // The unused code 2'b11 falls back to IDLE.
      default: state_next = IDLE;
    endcase
  end

  assign bus.O     = o_reg;
  assign bus.ready = ready_reg;
  assign bus.busy  = (state == RUN) || (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_square_seq.sv
// Directed bench for square_seq at N=4 (handshake corner cases) and N=8
// (every operand value).
module tb_square_seq;

  logic clk;
  logic rst;
  logic [1:0] state_dbg4;
  logic [1:0] state_dbg8;

  int vectors;
  int miscompares;

  square_seq_if #(.N(4)) if4 ();
  square_seq_if #(.N(8)) if8 ();

  square_seq #(.N(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .bus       (if4),
    .state_dbg (state_dbg4)
  );

  square_seq #(.N(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .bus       (if8),
    .state_dbg (state_dbg8)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One N=4 operation with start pulsed for a single edge; A is scrambled
  // right after acceptance to show it is not re-sampled.
  task automatic run4(input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] old_o;
    old_o = if4.O;
    if4.start = 1'b1;
    if4.A     = a;
    step();
    if4.start = 1'b0;
    if4.A     = ~a;
    chk("run4_busy_t0", if4.busy, 1'b1);
    chk("run4_ready_t0", if4.ready, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("run4_busy", if4.busy, 1'b1);
      chk("run4_ready_low", if4.ready, 1'b0);
      chk("run4_o_hold", if4.O, old_o);
    end
    step();
    chk("run4_ready", if4.ready, 1'b1);
    chk("run4_busy_done", if4.busy, 1'b0);
    chk("run4_o", if4.O, exp);
  endtask

  task automatic run8(input logic [7:0] a);
    logic [15:0] exp;
    logic [15:0] old_o;
    exp   = 16'(a) * 16'(a);
    old_o = if8.O;
    if8.start = 1'b1;
    if8.A     = a;
    step();
    if8.start = 1'b0;
    if8.A     = 8'($urandom_range(0, 255));
    chk("run8_ready_t0", if8.ready, 1'b0);
    for (int i = 0; i < 9; i++) begin
      chk("run8_busy", if8.busy, 1'b1);
      chk("run8_o_hold", if8.O, old_o);
      step();
    end
    chk("run8_ready", if8.ready, 1'b1);
    chk("run8_busy_done", if8.busy, 1'b0);
    chk("run8_o", if8.O, exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    if4.start   = 1'b0;
    if4.A       = '0;
    if8.start   = 1'b0;
    if8.A       = '0;
    repeat (2) step();
    chk("rst_o4", if4.O, 8'd0);
    chk("rst_ready4", if4.ready, 1'b0);
    chk("rst_busy4", if4.busy, 1'b0);
    chk("rst_state4", state_dbg4, 2'd0);
    chk("rst_o8", if8.O, 16'd0);
    chk("rst_busy8", if8.busy, 1'b0);
    rst = 1'b1;
    step();
    chk("idle_hold_busy", if4.busy, 1'b0);

    // Zero operand and maximum operand.
    run4(4'd0, 8'd0);
    run4(4'd15, 8'd225);

    // Back-to-back with start held: 9 then 6, six cycles apart.
    if4.start = 1'b1;
    if4.A     = 4'd9;
    step();
    chk("b2b_ready_clr1", if4.ready, 1'b0);
    if4.A = 4'd6;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("b2b_ready_low1", if4.ready, 1'b0);
      chk("b2b_o_hold1", if4.O, 8'd225);
    end
    step();
    chk("b2b_ready1", if4.ready, 1'b1);
    chk("b2b_o1", if4.O, 8'd81);
    step();
    chk("b2b_ready_clr2", if4.ready, 1'b0);
    chk("b2b_busy2", if4.busy, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("b2b_ready_low2", if4.ready, 1'b0);
      chk("b2b_o_hold2", if4.O, 8'd81);
    end
    step();
    if4.start = 1'b0;
    chk("b2b_ready2", if4.ready, 1'b1);
    chk("b2b_o2", if4.O, 8'd36);

    // Start during RUN is ignored and not queued.
    if4.start = 1'b1;
    if4.A     = 4'd5;
    step();
    if4.start = 1'b0;
    step();
    step();
    if4.start = 1'b1;
    if4.A     = 4'd3;
    step();
    if4.start = 1'b0;
    if4.A     = 4'd10;
    chk("ign_busy", if4.busy, 1'b1);
    step();
    step();
    chk("ign_ready", if4.ready, 1'b1);
    chk("ign_o", if4.O, 8'd25);
    step();
    chk("ign_no_queue", if4.busy, 1'b0);
    chk("ign_ready_level", if4.ready, 1'b1);

    // Asynchronous reset in the middle of RUN.
    if4.start = 1'b1;
    if4.A     = 4'd13;
    step();
    if4.start = 1'b0;
    step();
    step();
    #3;
    rst = 1'b0;
    #1;
    chk("arst_o", if4.O, 8'd0);
    chk("arst_ready", if4.ready, 1'b0);
    chk("arst_busy", if4.busy, 1'b0);
    chk("arst_state", state_dbg4, 2'd0);
    step();
    rst = 1'b1;
    step();
    run4(4'd2, 8'd4);

    // N=8: every operand value.
    for (int a = 0; a < 256; a++) begin
      run8(8'(a));
    end
    chk("n8_last", if8.O, 16'd65025);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
